// File: rtl/gmux_quad_ctrl_if.sv
// Request/control bundle between the clock controller and the GMUX sequencer.
// Latency: none (pure wiring).
// Backpressure: REQ_VALID/REQ_READY handshake; DYN_GATE only with GMUX_QUAD_CTRL_DYN_EN.
interface gmux_quad_ctrl_if;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic       SEL_REQ;
    logic [3:0] QEN_REQ;
    logic       LP_REQ;
`ifdef GMUX_QUAD_CTRL_DYN_EN
    logic [3:0] DYN_GATE;
`endif
    logic       SSEL;
    logic [3:0] SEN;
    logic [3:0] DEN;
    logic [3:0] DYNEN;
    logic [3:0] VLP;
    logic       BUSY;
    logic       DONE;

    // Requester side (power/clock controller)
    modport master (
`ifdef GMUX_QUAD_CTRL_DYN_EN
        output DYN_GATE,
`endif
        output REQ_VALID, SEL_REQ, QEN_REQ, LP_REQ,
        input  REQ_READY, SSEL, SEN, DEN, DYNEN, VLP, BUSY, DONE
    );

    // Sequencer side
    modport slave (
`ifdef GMUX_QUAD_CTRL_DYN_EN
        input  DYN_GATE,
`endif
        input  REQ_VALID, SEL_REQ, QEN_REQ, LP_REQ,
        output REQ_READY, SSEL, SEN, DEN, DYNEN, VLP, BUSY, DONE
    );
endinterface

// File: rtl/gmux_quad_ctrl.sv
// Glitch-free GMUX select/quadrant-enable sequencer (gate, settle, switch, settle, ungate).
// Latency: switch request DONE at A+2*SETTLE_CYCLES+3, same-source request DONE at A+1.
// Backpressure: REQ_READY low for the whole sequence; optional DYN_GATE via GMUX_QUAD_CTRL_DYN_EN.
module gmux_quad_ctrl #(
    parameter int SETTLE_CYCLES = 4   // 1..255
) (
    input  logic             CLK,
    input  logic             RST,
    gmux_quad_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GATE    = 3'd1,
        S_SETTLE1 = 3'd2,
        S_SWITCH  = 3'd3,
        S_SETTLE2 = 3'd4,
        S_UNGATE  = 3'd5
    } state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sel_q, sel_d;
    logic [3:0] qen_q, qen_d;
    logic       ssel_q, ssel_d;
    logic [3:0] sen_q, sen_d;
    logic [3:0] den_q, den_d;
    logic [3:0] dynen_q, dynen_d;
    logic [3:0] vlp_q, vlp_d;
    logic       rdy_q, rdy_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       accept;

    assign accept = bus.REQ_VALID & rdy_q;

    // State and output registers; reset restores idle defaults and drops any in-flight request
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= 1'b0;
            qen_q   <= '0;
            ssel_q  <= 1'b0;
            sen_q   <= 4'b1111;
            den_q   <= '0;
            dynen_q <= '0;
            vlp_q   <= '0;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            qen_q   <= qen_d;
            ssel_q  <= ssel_d;
            sen_q   <= sen_d;
            den_q   <= den_d;
            dynen_q <= dynen_d;
            vlp_q   <= vlp_d;
            rdy_q   <= rdy_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state: a request for the current source skips straight to ungating
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (accept) state_d = (bus.SEL_REQ == ssel_q) ? S_UNGATE : S_GATE;
            S_GATE:    state_d = S_SETTLE1;
            S_SETTLE1: if (cnt_q == 8'd0) state_d = S_SWITCH;
            S_SWITCH:  state_d = S_SETTLE2;
            S_SETTLE2: if (cnt_q == 8'd0) state_d = S_UNGATE;
            S_UNGATE:  state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Output next-values: SSEL only moves while every quadrant is gated, VLP never overlaps SEN
    always_comb begin
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        qen_d   = qen_q;
        ssel_d  = ssel_q;
        sen_d   = sen_q;
        vlp_d   = vlp_q;
        den_d   = '0;
        dynen_d = '0;
        done_d  = 1'b0;
        rdy_d   = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                vlp_d = {4{bus.LP_REQ}} & ~sen_q;
`ifdef GMUX_QUAD_CTRL_DYN_EN
                den_d   = bus.DYN_GATE & sen_q;
                dynen_d = sen_q;
`endif
                if (accept) begin
                    sel_d = bus.SEL_REQ;
                    qen_d = bus.QEN_REQ;
                end
            end
            S_GATE: begin
                sen_d = '0;
                cnt_d = RELOAD;
            end
            S_SETTLE1, S_SETTLE2: begin
                if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
            end
            S_SWITCH: begin
                ssel_d = sel_q;
                cnt_d  = RELOAD;
            end
            S_UNGATE: begin
                sen_d  = qen_q;
                vlp_d  = {4{bus.LP_REQ}} & ~qen_q;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.REQ_READY = rdy_q;
    assign bus.BUSY      = busy_q;
    assign bus.DONE      = done_q;
    assign bus.SSEL      = ssel_q;
    assign bus.SEN       = sen_q;
    assign bus.DEN       = den_q;
    assign bus.DYNEN     = dynen_q;
    assign bus.VLP       = vlp_q;

endmodule

// File: tb/tb_gmux_quad_ctrl.sv
// Scoreboard bench for gmux_quad_ctrl: directed requests push expected completions, a monitor checks DONE.
// Latency: checks exact DONE cycle relative to the accept edge.
// Backpressure: holds REQ_VALID until REQ_READY; all waits bounded.
module tb_gmux_quad_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    gmux_quad_ctrl_if bus ();

    gmux_quad_ctrl #(.SETTLE_CYCLES(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       ssel;
        logic [3:0] sen;
        logic [3:0] vlp;
        int         lat;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = 0;
    int   a_cyc  = 0;
    bit   mon_en = 1'b0;
    logic acc    = 1'b0;
    logic prev_ssel;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Capture whether this edge is an accept edge (pre-edge values)
    always @(posedge CLK) acc <= bus.REQ_VALID & bus.REQ_READY;

    // Monitor: pops the scoreboard on every DONE and checks per-cycle invariants
    initial begin
        forever begin
            @(posedge CLK);
            #1;
            cyc++;
            if (acc) a_cyc = cyc;
            if (mon_en) begin
                chk("inv_vlp_sen", {4'b0, bus.VLP & bus.SEN}, 8'h00);
                if (bus.SSEL !== prev_ssel) chk("ssel_chg_gated", {4'b0, bus.SEN}, 8'h00);
`ifndef GMUX_QUAD_CTRL_DYN_EN
                chk("den_const", {4'b0, bus.DEN}, 8'h00);
                chk("dynen_const", {4'b0, bus.DYNEN}, 8'h00);
`endif
                if (bus.DONE === 1'b1) begin
                    if (sbq.size() == 0) begin
                        chk("done_unexpected", {7'b0, bus.DONE}, 8'h00);
                    end else begin
                        exp_t e;
                        e = sbq.pop_front();
                        chk("done_ssel", {7'b0, bus.SSEL}, {7'b0, e.ssel});
                        chk("done_sen", {4'b0, bus.SEN}, {4'b0, e.sen});
                        chk("done_vlp", {4'b0, bus.VLP}, {4'b0, e.vlp});
                        chk("done_lat", 8'(cyc - a_cyc), 8'(e.lat));
                        chk("done_rdy", {7'b0, bus.REQ_READY}, 8'h01);
                    end
                end
            end
            prev_ssel = bus.SSEL;
        end
    end

    // Issue one request at a negedge; returns at the negedge after the accept edge
    task automatic issue(input logic sel, input logic [3:0] qen, input logic [3:0] vlp,
                         input int lat, input bit push, output int waited);
        exp_t e;
        if (push) begin
            e.ssel = sel; e.sen = qen; e.vlp = vlp; e.lat = lat;
            sbq.push_back(e);
        end
        bus.REQ_VALID = 1'b1;
        bus.SEL_REQ   = sel;
        bus.QEN_REQ   = qen;
        waited = 0;
        while (bus.REQ_READY !== 1'b1 && waited < 100) begin
            @(negedge CLK);
            waited++;
        end
        chk("accept_timeout", {7'b0, waited < 100}, 8'h01);
        @(posedge CLK);
        @(negedge CLK);
        bus.REQ_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.REQ_READY !== 1'b1 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_timeout", {7'b0, n < 100}, 8'h01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        bus.REQ_VALID = 1'b0;
        bus.SEL_REQ   = 1'b0;
        bus.QEN_REQ   = 4'b0;
        bus.LP_REQ    = 1'b0;
`ifdef GMUX_QUAD_CTRL_DYN_EN
        bus.DYN_GATE  = 4'b0;
`endif
        // Reset for two cycles
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ssel", {7'b0, bus.SSEL}, 8'h00);
        chk("rst_sen", {4'b0, bus.SEN}, 8'h0F);
        chk("rst_den", {4'b0, bus.DEN}, 8'h00);
        chk("rst_dynen", {4'b0, bus.DYNEN}, 8'h00);
        chk("rst_vlp", {4'b0, bus.VLP}, 8'h00);
        chk("rst_rdy", {7'b0, bus.REQ_READY}, 8'h01);
        chk("rst_busy", {7'b0, bus.BUSY}, 8'h00);
        chk("rst_done", {7'b0, bus.DONE}, 8'h00);
        RST = 1'b0;
        prev_ssel = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge CLK);

        // Same source: no gating gap, DONE at A+1
        issue(1'b0, 4'b0011, 4'b0000, 1, 1'b1, w);
        wait_idle();

        // Low power on disabled quadrants, one cycle later
        bus.LP_REQ = 1'b1;
        chk("lp_before", {4'b0, bus.VLP}, 8'h00);
        @(posedge CLK); #1;
        chk("lp_after", {4'b0, bus.VLP}, 8'h0C);
        @(negedge CLK);

        // Enabling all quadrants clears VLP together with SEN
        issue(1'b0, 4'b1111, 4'b0000, 1, 1'b1, w);
        wait_idle();
        bus.LP_REQ = 1'b0;
        @(negedge CLK);

        // Source switch: gate at A+1, SSEL at A+6, DONE at A+11
        issue(1'b1, 4'b1010, 4'b0000, 11, 1'b1, w);
        @(posedge CLK); #1;
        chk("sw_sen_gated", {4'b0, bus.SEN}, 8'h00);
        chk("sw_ssel_a1", {7'b0, bus.SSEL}, 8'h00);
        chk("sw_busy", {7'b0, bus.BUSY}, 8'h01);
        chk("sw_rdy", {7'b0, bus.REQ_READY}, 8'h00);
        repeat (4) @(posedge CLK); #1;
        chk("sw_ssel_a5", {7'b0, bus.SSEL}, 8'h00);
        @(posedge CLK); #1;
        chk("sw_ssel_a6", {7'b0, bus.SSEL}, 8'h01);
        chk("sw_sen_a6", {4'b0, bus.SEN}, 8'h00);
        wait_idle();

        // Request held while busy: accepted only at the edge ending the DONE cycle
        issue(1'b0, 4'b0110, 4'b0000, 11, 1'b1, w);
        repeat (3) @(negedge CLK);
        issue(1'b1, 4'b1111, 4'b0000, 11, 1'b1, w);
        chk("busy_wait", 8'(w), 8'd8);
        wait_idle();

        // Reset during SETTLE2 abandons the request without DONE
        issue(1'b0, 4'b0101, 4'b0000, 11, 1'b0, w);
        repeat (7) @(negedge CLK);
        chk("s2_busy", {7'b0, bus.BUSY}, 8'h01);
        chk("s2_ssel", {7'b0, bus.SSEL}, 8'h00);
        chk("s2_sen", {4'b0, bus.SEN}, 8'h00);
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("mrst_ssel", {7'b0, bus.SSEL}, 8'h00);
        chk("mrst_sen", {4'b0, bus.SEN}, 8'h0F);
        chk("mrst_rdy", {7'b0, bus.REQ_READY}, 8'h01);
        chk("mrst_busy", {7'b0, bus.BUSY}, 8'h00);
        chk("mrst_done", {7'b0, bus.DONE}, 8'h00);
        @(negedge CLK);
        RST = 1'b0;
        repeat (15) @(negedge CLK);

`ifdef GMUX_QUAD_CTRL_DYN_EN
        // Dynamic gating follows SEN in IDLE, forced off during the sequence
        bus.DYN_GATE = 4'b0101;
        @(posedge CLK); #1;
        chk("dyn_den", {4'b0, bus.DEN}, 8'h05);
        chk("dyn_dynen", {4'b0, bus.DYNEN}, 8'h0F);
        @(negedge CLK);
        issue(1'b1, 4'b1100, 4'b0000, 11, 1'b1, w);
        @(posedge CLK); #1;
        chk("dyn_gate_den", {4'b0, bus.DEN}, 8'h00);
        chk("dyn_gate_dynen", {4'b0, bus.DYNEN}, 8'h00);
        wait_idle();
        chk("dyn_done_den", {4'b0, bus.DEN}, 8'h00);
        chk("dyn_done_dynen", {4'b0, bus.DYNEN}, 8'h00);
        @(posedge CLK); #1;
        chk("dyn_ret_den", {4'b0, bus.DEN}, 8'h04);
        chk("dyn_ret_dynen", {4'b0, bus.DYNEN}, 8'h0C);
        @(negedge CLK);
`endif

        repeat (3) @(negedge CLK);
        chk("sb_empty", 8'(sbq.size()), 8'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
